// File: rtl/jk_universal_reg.sv
// N-bit universal register: a per-bit mode decoder drives J/K into an array of JK cells.
// Optional build macro JKREG_CNT_SAT_EN makes up/down counting saturate instead of wrap.
module jk_universal_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_JK    = 3'b010;
  localparam logic [2:0] M_TOG   = 3'b011;
  localparam logic [2:0] M_SHL   = 3'b100;
  localparam logic [2:0] M_SHR   = 3'b101;
  localparam logic [2:0] M_UP    = 3'b110;
  localparam logic [2:0] M_DOWN  = 3'b111;

  logic [WIDTH-1:0] j_drv;
  logic [WIDTH-1:0] k_drv;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] shl_v;
  logic [WIDTH-1:0] shr_v;
  logic [WIDTH-1:0] q_nxt;
  logic             at_max;
  logic             at_min;

  // Ripple toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic acc_up;
    logic acc_dn;
    acc_up = 1'b1;
    acc_dn = 1'b1;
    up_t   = '0;
    dn_t   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      up_t[i] = acc_up;
      dn_t[i] = acc_dn;
      acc_up  = acc_up & q[i];
      acc_dn  = acc_dn & ~q[i];
    end
  end

  assign at_max = &q;
  assign at_min = ~|q;
  assign shl_v  = {q[WIDTH-2:0], sin};
  assign shr_v  = {sin, q[WIDTH-1:1]};

  // Mode decoder: every operation becomes a per-bit J/K drive.
  always_comb begin
    j_drv = '0;
    k_drv = '0;
    if (en) begin
      case (mode)
        M_HOLD: begin
          j_drv = '0;
          k_drv = '0;
        end
        M_LOAD: begin
          j_drv = d;
          k_drv = ~d;
        end
        M_JK: begin
          j_drv = j;
          k_drv = k;
        end
        M_TOG: begin
          j_drv = d;
          k_drv = d;
        end
        M_SHL: begin
          j_drv = shl_v;
          k_drv = ~shl_v;
        end
        M_SHR: begin
          j_drv = shr_v;
          k_drv = ~shr_v;
        end
        M_UP: begin
`ifdef JKREG_CNT_SAT_EN
          if (!at_max) begin
            j_drv = up_t;
            k_drv = up_t;
          end
`else
          j_drv = up_t;
          k_drv = up_t;
`endif
        end
        M_DOWN: begin
`ifdef JKREG_CNT_SAT_EN
          if (!at_min) begin
            j_drv = dn_t;
            k_drv = dn_t;
          end
`else
          j_drv = dn_t;
          k_drv = dn_t;
`endif
        end
        default: begin
          j_drv = '0;
          k_drv = '0;
        end
      endcase
    end
  end

  // JK cell characteristic equation, one cell per bit.
  assign q_nxt = (j_drv & ~q) | (~k_drv & q);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else begin
      q <= q_nxt;
    end
  end

  assign qb = ~q;
  assign tc = ~rst & en & (((mode == M_UP) & at_max) | ((mode == M_DOWN) & at_min));

endmodule

// File: tb/tb_jk_universal_reg.sv
// Scoreboard bench for jk_universal_reg: driver queues expected tc/q, monitor pops and compares.
module tb_jk_universal_reg;

  typedef struct {
    logic       tc;
    logic [7:0] q;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] j;
  logic [7:0] k;
  logic       sin;
  logic [7:0] q;
  logic [7:0] qb;
  logic       tc;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jk_universal_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .j(j), .k(k),
    .sin(sin), .q(q), .qb(qb), .tc(tc)
  );

  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] dv, input logic [7:0] jv, input logic [7:0] kv,
                      input logic s, input logic et, input logic [7:0] eq);
    exp_t it;
    @(negedge clk);
    rst  = r;
    en   = e;
    mode = m;
    d    = dv;
    j    = jv;
    k    = kv;
    sin  = s;
    it.tc = et;
    it.q  = eq;
    sb.push_back(it);
  endtask

  // Monitor: tc checked with inputs applied, q/qb checked just after the edge.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        it = sb[0];
        checks++;
        if (tc !== it.tc) begin
          errors++;
          $display("FAIL tc t=%0t got %b want %b", $time, tc, it.tc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (q !== it.q) begin
          errors++;
          $display("FAIL q t=%0t got %h want %h", $time, q, it.q);
        end
        checks++;
        if (qb !== ~it.q) begin
          errors++;
          $display("FAIL qb t=%0t got %h want %h", $time, qb, ~it.q);
        end
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; mode = 3'b110; d = '0; j = '0; k = '0; sin = 1'b0;
    // reset with counting requested: no increment
    step(1, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA5);
    step(1, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA5);
    // load / JK / toggle
    step(0, 1, 3'b001, 8'h3C, 8'h00, 8'h00, 0, 0, 8'h3C);
    step(0, 1, 3'b010, 8'h00, 8'hF0, 8'h0F, 0, 0, 8'hF0);
    step(0, 1, 3'b010, 8'h00, 8'hFF, 8'hFF, 0, 0, 8'h0F);
    step(0, 1, 3'b011, 8'h01, 8'h00, 8'h00, 0, 0, 8'h0E);
    // shift, with j/k/sin noise on the load
    step(0, 1, 3'b001, 8'h81, 8'hFF, 8'hFF, 1, 0, 8'h81);
    step(0, 1, 3'b100, 8'hFF, 8'hFF, 8'hFF, 0, 0, 8'h02);
    step(0, 1, 3'b101, 8'h00, 8'h00, 8'h00, 1, 0, 8'h81);
    step(0, 0, 3'b110, 8'h00, 8'h00, 8'h00, 1, 0, 8'h81);
    step(0, 0, 3'b001, 8'h00, 8'h00, 8'h00, 1, 0, 8'h81);
    step(0, 0, 3'b100, 8'h00, 8'h00, 8'h00, 1, 0, 8'h81);
    // count boundaries
    step(0, 1, 3'b001, 8'hFE, 8'h00, 8'h00, 0, 0, 8'hFE);
    step(0, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 0, 8'hFF);
`ifdef JKREG_CNT_SAT_EN
    step(0, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 1, 8'hFF);
    step(0, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 1, 8'hFF);
    step(0, 1, 3'b001, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00);
    step(0, 1, 3'b111, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00);
    step(0, 1, 3'b111, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00);
`else
    step(0, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00);
    step(0, 1, 3'b111, 8'h00, 8'h00, 8'h00, 0, 1, 8'hFF);
    step(0, 1, 3'b111, 8'h00, 8'h00, 8'h00, 0, 0, 8'hFE);
    step(0, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 0, 8'hFF);
    step(0, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00);
`endif
    // reset in the middle of counting
    step(0, 1, 3'b001, 8'h10, 8'h00, 8'h00, 0, 0, 8'h10);
    step(0, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 0, 8'h11);
    step(0, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 0, 8'h12);
    step(1, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA5);
    step(0, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA6);
    step(0, 1, 3'b110, 8'h00, 8'h00, 8'h00, 0, 0, 8'hA7);
    step(0, 1, 3'b000, 8'hFF, 8'hFF, 8'h00, 1, 0, 8'hA7);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #5;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
